// File: rtl/ndp_buf_pkg.sv
// Shared definitions for the NDP buffer scheduler: FSM state encoding and
// the narrow/wide geometry helpers used to size the loaded-word bitmap.
package ndp_buf_pkg;

  // Load FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // empty, waiting for the first host word
  localparam logic [1:0] ST_LOAD = 2'd1;  // host stream in progress, reads overlap
  localparam logic [1:0] ST_FULL = 2'd2;  // load finished, read-only

  // Number of narrow A-words packed into one wide B-word
  function automatic int calc_ratio(input int b_width, input int a_width);
    return b_width / a_width;
  endfunction

  // Number of wide B-words held by the buffer
  function automatic int calc_b_depth(input int a_depth, input int ratio);
    return a_depth / ratio;
  endfunction

endpackage

// File: rtl/ndp_buf_sched.sv
// Load/read scheduler for the NDP dual-port buffer.
// The host streams narrow words into the A-port through an auto-incrementing
// pointer; a per-B-word bitmap tracks which wide words are complete so the
// compute engine can read them while the rest of the load is still running.
// Optional build macro: NDP_BUF_SCHED_PERF_EN adds the stall_cnt output.
module ndp_buf_sched
  import ndp_buf_pkg::*;
#(
  parameter int A_WIDTH         = 32,
  parameter int B_WIDTH         = 64,
  parameter int A_DEPTH         = 10,
  parameter int A_ADDRESS_WIDTH = 4,
  parameter int B_ADDRESS_WIDTH = 3,
  localparam int RATIO          = calc_ratio(B_WIDTH, A_WIDTH),
  localparam int B_DEPTH        = calc_b_depth(A_DEPTH, RATIO)
) (
  input  logic                       clk,
  input  logic                       rst,
  // host write stream
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [A_WIDTH-1:0]         wr_data,
  input  logic                       wr_last,
  // compute read request / response
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [B_ADDRESS_WIDTH-1:0] rd_req_addr,
  output logic                       rd_rsp_valid,
  output logic [B_WIDTH-1:0]         rd_rsp_data,
  output logic                       rd_rsp_err,
  // control / status
  input  logic                       clr,
  output logic                       loaded,
  output logic [B_DEPTH-1:0]         word_vld,
`ifdef NDP_BUF_SCHED_PERF_EN
  output logic [15:0]                stall_cnt,
`endif
  // buffer side
  output logic                       bram_wea,
  output logic [A_ADDRESS_WIDTH-1:0] bram_addra,
  output logic [A_WIDTH-1:0]         bram_dina,
  output logic [B_ADDRESS_WIDTH-1:0] bram_addrb,
  input  logic [B_WIDTH-1:0]         bram_doutb
);

  // Pointer is one bit wider than the A-port address so it can sit at A_DEPTH
  localparam int PW = A_ADDRESS_WIDTH + 1;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [B_DEPTH-1:0] word_vld_q, word_vld_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               clr_pend_q, clr_pend_d;

  logic               clr_req;
  logic               clr_take;
  logic               wr_acc;
  logic               rd_acc;
  logic               addr_in_range;
  logic               addr_vld;
  logic [PW-1:0]      b_idx;
  logic [PW-1:0]      lane;

  // Handshake decode: clr (live or deferred) refuses both ports for the cycle
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    clr_req       = clr || clr_pend_q;
    clr_take      = clr_req && !rsp_valid_q;
    addr_in_range = ({1'b0, rd_req_addr} < (B_ADDRESS_WIDTH + 1)'(B_DEPTH));
    addr_vld      = 1'b0;
    for (int i = 0; i < B_DEPTH; i++) begin
      if (rd_req_addr == B_ADDRESS_WIDTH'(i)) addr_vld = word_vld_q[i];
    end
    wr_ready     = !rst && !clr_req &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_LOAD) && (wptr_q < PW'(A_DEPTH))));
    rd_req_ready = !rst && !clr_req && (state_q != ST_IDLE) &&
                   (!addr_in_range || addr_vld);
    wr_acc       = wr_valid && wr_ready;
    rd_acc       = rd_req_valid && rd_req_ready;
  end

  // Next-state: load pointer, loaded-word bitmap, FSM, response pipe, clr deferral
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    word_vld_d  = word_vld_q;
    rsp_valid_d = rd_acc;
    rsp_err_d   = rd_acc && !addr_in_range;
    // A response leaving this cycle pushes clr back by one cycle
    clr_pend_d  = clr_req && rsp_valid_q;
    b_idx       = wptr_q / PW'(RATIO);
    lane        = wptr_q % PW'(RATIO);
    if (clr_take) begin
      state_d    = ST_IDLE;
      wptr_d     = '0;
      word_vld_d = '0;
    end else if (wr_acc) begin
      wptr_d = wptr_q + PW'(1);
      // The word becomes readable at the same edge its last lane is written
      for (int i = 0; i < B_DEPTH; i++) begin
        if ((b_idx == PW'(i)) && ((lane == PW'(RATIO - 1)) || wr_last))
          word_vld_d[i] = 1'b1;
      end
      if (wr_last || (wptr_q == PW'(A_DEPTH - 1))) state_d = ST_FULL;
      else                                        state_d = ST_LOAD;
    end
  end

  // State registers; buffer contents live outside and are never cleared here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      word_vld_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      word_vld_q  <= word_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  // Buffer drive and status outputs; read data is the buffer's registered output
  always_comb begin
    bram_wea     = wr_acc;
    bram_addra   = wptr_q[A_ADDRESS_WIDTH-1:0];
    bram_dina    = wr_data;
    bram_addrb   = (state_q == ST_IDLE) ? '0 : rd_req_addr;
    loaded       = (state_q == ST_FULL);
    word_vld     = word_vld_q;
    rd_rsp_valid = rsp_valid_q;
    rd_rsp_err   = rsp_err_q;
    rd_rsp_data  = (rsp_valid_q && !rsp_err_q) ? bram_doutb : '0;
  end

`ifdef NDP_BUF_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a read request waits on its word
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_take)
      stall_cnt_d = '0;
    else if (rd_req_valid && !rd_req_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ndp_buf_sched.sv
// Directed bench for ndp_buf_sched with a behavioural dual-port buffer.
// Inputs change just after the falling edge; outputs are compared 1 ns later.
module tb_ndp_buf_sched;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [2:0]  rd_req_addr;
  logic        rd_rsp_valid;
  logic [63:0] rd_rsp_data;
  logic        rd_rsp_err;
  logic        clr;
  logic        loaded;
  logic [4:0]  word_vld;
  logic        bram_wea;
  logic [3:0]  bram_addra;
  logic [31:0] bram_dina;
  logic [2:0]  bram_addrb;
  logic [63:0] bram_doutb;
`ifdef NDP_BUF_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ndp_buf_sched dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .clr          (clr),
    .loaded       (loaded),
    .word_vld     (word_vld),
`ifdef NDP_BUF_SCHED_PERF_EN
    .stall_cnt    (stall_cnt),
`endif
    .bram_wea     (bram_wea),
    .bram_addra   (bram_addra),
    .bram_dina    (bram_dina),
    .bram_addrb   (bram_addrb),
    .bram_doutb   (bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer: 16 narrow lanes so any 3-bit B address is legal
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    bram_doutb <= {mem[{bram_addrb, 1'b1}], mem[{bram_addrb, 1'b0}]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h0;
    bram_doutb   = '0;
    rst          = 1'b1;
    wr_valid     = 1'b1;   // must be ignored while in reset
    wr_data      = 32'h0;
    wr_last      = 1'b0;
    rd_req_valid = 1'b0;
    rd_req_addr  = 3'd0;
    clr          = 1'b0;

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_ready", wr_ready, 0);
    check("rst_wea", bram_wea, 0);
    check("rst_addra", bram_addra, 0);
    check("rst_addrb", bram_addrb, 0);
    check("rst_word_vld", word_vld, 0);
    check("rst_loaded", loaded, 0);
    check("rst_rsp_valid", rd_rsp_valid, 0);
    check("rst_rsp_err", rd_rsp_err, 0);
    check("rst_rsp_data", rd_rsp_data, 0);
    @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("idle_wr_ready", wr_ready, 1);

    // ---- IDLE refuses reads: hold a request for 5 cycles
    rd_req_valid = 1'b1;
    rd_req_addr  = 3'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("idle_rd_ready", rd_req_ready, 0);
      @(negedge clk);
    end
    rd_req_valid = 1'b0;
    #1;
`ifdef NDP_BUF_SCHED_PERF_EN
    check("stall_cnt_5", stall_cnt, 16'd5);
`endif
    clr = 1'b1;
    #1;
    check("clr_blocks_wr", wr_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
`ifdef NDP_BUF_SCHED_PERF_EN
    check("stall_cnt_clr", stall_cnt, 16'd0);
`endif
    check("after_clr_wr_ready", wr_ready, 1);

    // ---- full load 0x100..0x109 with a read of word 3 waiting from the start
    for (int i = 0; i < 10; i++) begin
      wr_valid     = 1'b1;
      wr_data      = 32'h100 + 32'(i);
      wr_last      = (i == 9);
      rd_req_valid = (i <= 8);
      rd_req_addr  = 3'd3;
      #1;
      check("load_wr_ready", wr_ready, 1);
      check("load_wea", bram_wea, 1);
      check("load_addra", bram_addra, 64'(i));
      check("load_word_vld", word_vld, 64'((5'd1 << (i / 2)) - 5'd1));
      check("load_loaded", loaded, 0);
      if (i <= 8) check("load_rd3_ready", rd_req_ready, 64'(i == 8));
      if (i == 9) begin
        check("rd3_rsp_valid", rd_rsp_valid, 1);
        check("rd3_rsp_err", rd_rsp_err, 0);
        check("rd3_rsp_data", rd_rsp_data, 64'h00000107_00000106);
      end
      @(negedge clk);
    end
    wr_last      = 1'b0;
    rd_req_valid = 1'b0;
    // wr_valid stays high: a word presented in FULL must be held off
    wr_data      = 32'h1FF;
    #1;
    check("full_word_vld", word_vld, 5'b11111);
    check("full_loaded", loaded, 1);
    check("full_wr_ready", wr_ready, 0);
    check("full_wea", bram_wea, 0);
    check("full_rsp_valid", rd_rsp_valid, 0);

    // ---- out-of-range read, back-to-back with a read of word 4
    wr_valid     = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr  = 3'd6;
    #1;
    check("rd6_ready", rd_req_ready, 1);
    check("rd6_addrb", bram_addrb, 3'd6);
    @(negedge clk);
    rd_req_addr = 3'd4;
    #1;
    check("rd6_rsp_valid", rd_rsp_valid, 1);
    check("rd6_rsp_err", rd_rsp_err, 1);
    check("rd6_rsp_data", rd_rsp_data, 0);
    check("rd4_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    #1;
    check("rd4_rsp_valid", rd_rsp_valid, 1);
    check("rd4_rsp_err", rd_rsp_err, 0);
    check("rd4_rsp_data", rd_rsp_data, 64'h00000109_00000108);

    // ---- clr the cycle after a read accept: deferred by one cycle
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = 3'd0;
    #1;
    check("rd0_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_valid = 1'b0;
    clr          = 1'b1;
    #1;
    check("clr_rsp_valid", rd_rsp_valid, 1);
    check("clr_rsp_data", rd_rsp_data, 64'h00000101_00000100);
    check("clr_wr_ready", wr_ready, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr_deferred_vld", word_vld, 5'b11111);
    check("clr_deferred_loaded", loaded, 1);
    check("clr_deferred_rsp", rd_rsp_valid, 0);
    @(negedge clk);
    #1;
    check("clr_done_vld", word_vld, 0);
    check("clr_done_loaded", loaded, 0);
    check("clr_done_wr_ready", wr_ready, 1);

    // ---- short load: wr_last on the 3rd word
    for (int j = 0; j < 3; j++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA + 32'(j);
      wr_last  = (j == 2);
      #1;
      check("short_addra", bram_addra, 64'(j));
      check("short_wea", bram_wea, 1);
      @(negedge clk);
    end
    wr_data = 32'hD;
    wr_last = 1'b0;
    #1;
    check("short_word_vld", word_vld, 5'b00011);
    check("short_loaded", loaded, 1);
    check("short_wr_ready", wr_ready, 0);
    check("short_wea_held", bram_wea, 0);
    wr_valid     = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr  = 3'd1;
    #1;
    check("short_rd1_ready", rd_req_ready, 1);
    @(negedge clk);
    rd_req_addr = 3'd2;
    #1;
    // upper lane of the partial word keeps the stale value from the first load
    check("short_rd1_data", rd_rsp_data, 64'h00000103_0000000C);
    check("short_rd2_ready", rd_req_ready, 0);
    @(negedge clk);
    rd_req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ndp_buf_sched.md
Name: ndp_buf_sched

Overview:
- Controller and scheduler for the NDP dual-port buffer. Narrow A-port is written by a host stream; wide B-port is read by the compute engine.
- Sequences A-port writes with an auto-incrementing pointer.
- Tracks which wide B-words are fully loaded. Admits compute reads only for loaded words, so reads may overlap with loading.
- Owns load/clear sequencing of the buffer. Instantiated next to the buffer inside the NDP unit.

Parameters:
- A_WIDTH, 32, narrow write word width
- B_WIDTH, 64, wide read word width; must be an integer multiple of A_WIDTH
- A_DEPTH, 10, number of A-words; must be a multiple of RATIO
- A_ADDRESS_WIDTH, 4, A-port address width
- B_ADDRESS_WIDTH, 3, B-port address width

Ports:
- clk  in  1  single clock for controller and buffer
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  host write word valid
- wr_ready  out  1  controller accepts host word
- wr_data  in  A_WIDTH  host write data
- wr_last  in  1  final word of the load
- rd_req_valid  in  1  compute read request valid
- rd_req_ready  out  1  request accepted
- rd_req_addr  in  B_ADDRESS_WIDTH  B-word index
- rd_rsp_valid  out  1  read data valid (no backpressure)
- rd_rsp_data  out  B_WIDTH  read data
- rd_rsp_err  out  1  response for an out-of-range address
- clr  in  1  request to discard contents and return to IDLE
- loaded  out  1  load finished (state FULL)
- word_vld  out  B_DEPTH  per-B-word loaded bitmap
- bram_wea  out  1  to buffer wea
- bram_addra  out  A_ADDRESS_WIDTH  to buffer addra
- bram_dina  out  A_WIDTH  to buffer dina
- bram_addrb  out  B_ADDRESS_WIDTH  to buffer addrb
- bram_doutb  in  B_WIDTH  from buffer doutb (registered, 1-cycle latency)

Behaviour:
- Reset (async): state IDLE, wptr=0, word_vld=0, wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_err=0, rd_rsp_data=0, loaded=0, bram_wea=0, bram_addra=0, bram_addrb=0. Buffer contents are not cleared.
- Derived: RATIO=B_WIDTH/A_WIDTH, B_DEPTH=A_DEPTH/RATIO.
- FSM IDLE: wr_ready=1 and rd_req_ready=0. On the first accepted write, go to LOAD.
- FSM LOAD: wr_ready=1 while wptr<A_DEPTH. A write is accepted when wr_valid && wr_ready.
  - bram_wea=wr_valid&&wr_ready (combinational), bram_addra=wptr, bram_dina=wr_data.
  - wptr increments on each accepted write.
  - When an accepted write has wptr%RATIO==RATIO-1, or has wr_last=1, set word_vld[wptr/RATIO] at that same edge.
  - Go to FULL on an accepted write with wr_last=1 or with wptr==A_DEPTH-1.
- FSM FULL: wr_ready=0, loaded=1. A write presented here is held off, not dropped.
- Read admission (LOAD or FULL): rd_req_ready = (rd_req_addr>=B_DEPTH) || word_vld[rd_req_addr]. bram_addrb=rd_req_addr (combinational).
  - Response comes one cycle after acceptance: rd_rsp_valid=1, rd_rsp_data=bram_doutb.
  - Out-of-range request: accepted, rd_rsp_err=1, rd_rsp_data=0.
  - Back-to-back accepts allowed; one response per accept, in order.
- Same-cycle write and read of the same B-word: the read is not admitted, because word_vld updates at the write edge. It is admitted from the next cycle, so no read-before-write hazard exists.
- Partial last B-word (wr_last on a non-aligned word): the word is marked valid; upper lanes hold stale buffer contents.
- clr: honoured in any state except when a response is due in the next cycle; in that case it is deferred one cycle. Taking effect means IDLE, wptr=0, word_vld=0. clr has priority over a same-cycle write or read request: both are refused that cycle.
- wptr wrap is impossible: write acceptance stops at A_DEPTH.

Optional Feature:
- Macro NDP_BUF_SCHED_PERF_EN.
- With it: extra output stall_cnt[15:0], reset 0. Increments each cycle rd_req_valid && !rd_req_ready; saturates at 16'hFFFF; cleared by clr.
- Without it: the port and counter do not exist.

Decomposition:
- Shared package ndp_buf_pkg holds the state enum (IDLE, LOAD, FULL) and the RATIO/B_DEPTH derivation constants.
- No sub-module needed; the counter and bitmap stay inline.

Test Plan:
- Reset, then 10 host words 0x100..0x109 with wr_last on the 10th:
  - bram_addra runs 0..9.
  - word_vld reaches 5'b11111.
  - loaded=1 the cycle after the 10th accept.
- Read addr 3 before word 3 is loaded:
  - rd_req_ready=0 until A-word 7 is accepted; ready on the next cycle.
  - Response data {0x107,0x106} one cycle after accept.
- Read addr 6 after full load -> accepted immediately; next cycle rd_rsp_valid=1, rd_rsp_err=1, data 0.
- wr_last on the 3rd word (0xA,0xB,0xC):
  - word_vld=5'b00011, state FULL.
  - A following wr_valid sees wr_ready=0.
- clr asserted the cycle after a read accept:
  - Response still delivered.
  - clr takes effect one cycle later: word_vld=0, wr_ready=1.
- PERF_EN: request addr 0 held for 5 stalled cycles -> stall_cnt=5; clr -> 0.
